// File: rtl/ctl_data_merge_if.sv
// AXI-Stream bundle shared by the data input, control input and merged output
// of ctl_data_merge.
interface ctl_data_merge_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
);
  logic [C_S_AXIS_DATA_WIDTH-1:0]   tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser;
  logic                             tvalid;
  logic                             tlast;
  logic                             tready;

  modport master (
    output tdata, tkeep, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/ctl_data_merge.sv
// Packet-granular 2:1 merger. The back-pressured data stream and the
// ready-less control stream are joined onto one registered AXI-Stream master.
// Control beats are buffered in a FIFO. Whole-packet admission guarantees
// that the FIFO never overflows. Only complete buffered packets take part in
// round-robin arbitration against data packets.
module ctl_data_merge #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CTL_FIFO_DEPTH       = 16,
  parameter int MAX_CTL_BEATS        = 4
) (
  input  logic                clk,
  input  logic                aresetn,
  ctl_data_merge_if.slave     s_axis,
  ctl_data_merge_if.slave     c_s_axis,
  ctl_data_merge_if.master    m_axis,
  output logic [31:0]         ctl_drop_cnt,
  output logic [31:0]         ctl_trunc_cnt
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int ENT_W  = 1 + C_S_AXIS_TUSER_WIDTH + KEEP_W + C_S_AXIS_DATA_WIDTH;
  localparam int AW     = $clog2(CTL_FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int BW     = $clog2(MAX_CTL_BEATS + 1);

  localparam logic LG_DATA = 1'b0;
  localparam logic LG_CTL  = 1'b1;

  typedef enum logic [1:0] {C_IDLE, C_ACCEPT, C_DROP} cstate_t;
  typedef enum logic [1:0] {IDLE, GNT_DATA, GNT_CTL} astate_t;

  // Control FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem_q [CTL_FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    occ_q, occ_d;
  logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [ENT_W-1:0] head;
  logic             head_last;

  // Admission FSM
  cstate_t          cst_q, cst_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [BW-1:0]    beat_num;
  logic             has_room;
  logic             trunc_now;
  logic             wr_en, wr_last, drop_inc, trunc_inc;
  logic [31:0]      drop_cnt_q, trunc_cnt_q;

  // Arbiter FSM
  astate_t          ast_q, ast_d;
  logic             last_grant_q, last_grant_d;
  logic             ld, s_rdy, data_xfer, pop;

  // Output register
  logic                            m_tvalid_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  m_tdata_q;
  logic [KEEP_W-1:0]               m_tkeep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] m_tuser_q;
  logic                            m_tlast_q;

  // Free space is judged on start-of-cycle occupancy; a same-cycle pop is not credited.
  assign has_room  = (CW'(CTL_FIFO_DEPTH) - occ_q) >= CW'(MAX_CTL_BEATS);
  assign beat_num  = (cst_q == C_IDLE) ? BW'(1) : beat_cnt_q + BW'(1);
  assign trunc_now = !c_s_axis.tlast && (beat_num == BW'(MAX_CTL_BEATS));

  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[ENT_W-1];

  // Admission state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cst_q      <= C_IDLE;
      beat_cnt_q <= '0;
    end else begin
      cst_q      <= cst_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Admission next state: whole packets are either taken or refused at their first beat
  always_comb begin
    cst_d = cst_q;
    unique case (cst_q)
      C_IDLE: begin
        if (c_s_axis.tvalid && !c_s_axis.tlast) begin
          if (!has_room || trunc_now) cst_d = C_DROP;
          else                        cst_d = C_ACCEPT;
        end
      end
      C_ACCEPT: begin
        if (c_s_axis.tvalid) begin
          if (c_s_axis.tlast) cst_d = C_IDLE;
          else if (trunc_now) cst_d = C_DROP;
        end
      end
      C_DROP: begin
        if (c_s_axis.tvalid && c_s_axis.tlast) cst_d = C_IDLE;
      end
      default: cst_d = C_IDLE;
    endcase
  end

  // Admission outputs: FIFO write strobe, forced tlast and counter strobes
  always_comb begin
    wr_en      = 1'b0;
    drop_inc   = 1'b0;
    wr_last    = c_s_axis.tlast || trunc_now;
    beat_cnt_d = beat_cnt_q;
    if (c_s_axis.tvalid) begin
      if (cst_q == C_IDLE) begin
        wr_en    = has_room;
        drop_inc = !has_room;
      end else if (cst_q == C_ACCEPT) begin
        wr_en    = 1'b1;
      end
    end
    trunc_inc = wr_en && trunc_now;
    if (wr_en) beat_cnt_d = beat_num;
  end

  // FIFO payload storage; contents are meaningless until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_last, c_s_axis.tuser, c_s_axis.tkeep, c_s_axis.tdata};
  end

  assign occ_d     = occ_q + CW'(wr_en) - CW'(pop);
  assign pkt_cnt_d = pkt_cnt_q + CW'(wr_en && wr_last) - CW'(pop && head_last);

  // FIFO pointers, occupancy, complete-packet count and drop/truncate counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      if (wr_en)     wr_ptr_q    <= wr_ptr_q + AW'(1);
      if (pop)       rd_ptr_q    <= rd_ptr_q + AW'(1);
      if (drop_inc)  drop_cnt_q  <= drop_cnt_q + 32'd1;
      if (trunc_inc) trunc_cnt_q <= trunc_cnt_q + 32'd1;
      occ_q     <= occ_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign ld = !m_tvalid_q || m_axis.tready;

  // Arbiter state register with round-robin memory
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ast_q        <= IDLE;
      last_grant_q <= LG_CTL;
    end else begin
      ast_q        <= ast_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbiter next state: grants are taken in IDLE and released only on tlast
  always_comb begin
    ast_d        = ast_q;
    last_grant_d = last_grant_q;
    unique case (ast_q)
      IDLE: begin
        if (pkt_cnt_q != '0 && s_axis.tvalid)
          ast_d = (last_grant_q == LG_CTL) ? GNT_DATA : GNT_CTL;
        else if (s_axis.tvalid)
          ast_d = GNT_DATA;
        else if (pkt_cnt_q != '0)
          ast_d = GNT_CTL;
      end
      GNT_DATA: begin
        if (data_xfer && s_axis.tlast) begin
          ast_d        = IDLE;
          last_grant_d = LG_DATA;
        end
      end
      GNT_CTL: begin
        if (pop && head_last) begin
          ast_d        = IDLE;
          last_grant_d = LG_CTL;
        end
      end
      default: ast_d = IDLE;
    endcase
  end

  // Arbiter outputs: data ready and FIFO pop both follow the output-register load condition
  always_comb begin
    s_rdy     = (ast_q == GNT_DATA) && ld;
    data_xfer = s_rdy && s_axis.tvalid;
    pop       = (ast_q == GNT_CTL) && ld && (occ_q != '0);
  end

  // Output register: loads the selected beat, or drops valid when nothing is selected
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else if (ld) begin
      m_tvalid_q <= data_xfer || pop;
      if (data_xfer) begin
        m_tdata_q <= s_axis.tdata;
        m_tkeep_q <= s_axis.tkeep;
        m_tuser_q <= s_axis.tuser;
        m_tlast_q <= s_axis.tlast;
      end else if (pop) begin
        {m_tlast_q, m_tuser_q, m_tkeep_q, m_tdata_q} <= head;
      end
    end
  end

  assign s_axis.tready   = s_rdy;
  // The control source cannot be stalled; every beat is either stored or discarded.
  assign c_s_axis.tready = 1'b1;

  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tkeep  = m_tkeep_q;
  assign m_axis.tuser  = m_tuser_q;
  assign m_axis.tlast  = m_tlast_q;

  assign ctl_drop_cnt  = drop_cnt_q;
  assign ctl_trunc_cnt = trunc_cnt_q;

endmodule
